// File: rtl/mc_ctl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// variable-latency memory handshake, stall, timeout/illegal traps and retire count.
module mc_ctl #(
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    input  logic               alu_zero,
    input  logic               stall,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               reg_dst,
    output logic               alu_src,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic               mem_err,
    output logic [CNT_W-1:0]   retired
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_RALU, C_SHIFT, C_IALU, C_LW, C_SW, C_BEQ, C_J, C_BAD} cls_t;

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b11000,
                           OP_NOR = 5'b10001, OP_OR  = 5'b11110, OP_XOR = 5'b10110,
                           OP_SLT = 5'b00111, OP_SLL = 5'b01000, OP_SRL = 5'b01001,
                           OP_SRA = 5'b01011;

    // Wait counter only needs to reach MEM_TIMEOUT-1; the trap fires on that cycle.
    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state;
    cls_t             cls_q, dec_cls;
    logic [4:0]       op_q, dec_op;
    logic [WC_W-1:0]  wcnt;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q, mem_err_q;
    logic             timeout;

    assign timeout = (MEM_TIMEOUT > 0) && !mem_ready && (wcnt == WC_LAST);

    always_comb begin
        dec_cls = C_BAD;
        dec_op  = OP_ADD;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin dec_cls = C_RALU;  dec_op = OP_ADD; end
                    6'b100010: begin dec_cls = C_RALU;  dec_op = OP_SUB; end
                    6'b100100: begin dec_cls = C_RALU;  dec_op = OP_AND; end
                    6'b100111: begin dec_cls = C_RALU;  dec_op = OP_NOR; end
                    6'b100101: begin dec_cls = C_RALU;  dec_op = OP_OR;  end
                    6'b100110: begin dec_cls = C_RALU;  dec_op = OP_XOR; end
                    6'b101010: begin dec_cls = C_RALU;  dec_op = OP_SLT; end
                    6'b000000: begin dec_cls = C_SHIFT; dec_op = OP_SLL; end
                    6'b000010: begin dec_cls = C_SHIFT; dec_op = OP_SRL; end
                    6'b000011: begin dec_cls = C_SHIFT; dec_op = OP_SRA; end
                    default:   dec_cls = C_BAD;
                endcase
            end
            6'b001000: begin dec_cls = C_IALU; dec_op = OP_ADD; end
            6'b001100: begin dec_cls = C_IALU; dec_op = OP_AND; end
            6'b001101: begin dec_cls = C_IALU; dec_op = OP_OR;  end
            6'b001110: begin dec_cls = C_IALU; dec_op = OP_XOR; end
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: begin dec_cls = C_BEQ; dec_op = OP_SUB; end
            6'b000010: dec_cls = C_J;
            default:   dec_cls = C_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            cls_q     <= C_RALU;
            op_q      <= OP_ADD;
            wcnt      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else if (!stall) begin
            case (state)
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        wcnt <= '0;
                        if (state == S_FETCH)   state <= S_DECODE;
                        else if (cls_q == C_LW) state <= S_WB;
                        else begin
                            state     <= S_FETCH;
                            retired_q <= retired_q + CNT_W'(1);
                        end
                    end else if (timeout) begin
                        mem_err_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                S_DECODE: begin
                    cls_q <= dec_cls;
                    op_q  <= dec_op;
                    if (dec_cls == C_BAD) begin
                        illegal_q <= 1'b1;
                        state     <= S_TRAP;
                    end else if (dec_cls == C_J) begin
                        retired_q <= retired_q + CNT_W'(1);
                        wcnt      <= '0;
                        state     <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wcnt <= '0;
                    if (cls_q == C_BEQ) begin
                        retired_q <= retired_q + CNT_W'(1);
                        state     <= S_FETCH;
                    end else if (cls_q == C_LW || cls_q == C_SW) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    retired_q <= retired_q + CNT_W'(1);
                    wcnt      <= '0;
                    state     <= S_FETCH;
                end
                default: state <= S_TRAP;
            endcase
        end
    end

    // Strobes drop under stall; address/mux selects keep their state values.
    always_comb begin
        logic [4:0] aop;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        aop        = OP_ADD;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read = !stall;
                    ir_write = mem_ready && !stall;
                    pc_write = mem_ready && !stall;
                end
                S_DECODE: begin
                    if (dec_cls == C_J) begin
                        pc_write = !stall;
                        pc_src   = 2'd2;
                    end
                end
                S_EXEC: begin
                    aop     = op_q;
                    alu_src = (cls_q == C_SHIFT) || (cls_q == C_IALU) ||
                              (cls_q == C_LW) || (cls_q == C_SW);
                    if (cls_q == C_BEQ) begin
                        pc_write = alu_zero && !stall;
                        pc_src   = 2'd1;
                    end
                end
                S_MEM: begin
                    iord      = 1'b1;
                    alu_src   = 1'b1;
                    mem_read  = (cls_q == C_LW) && !stall;
                    mem_write = (cls_q == C_SW) && !stall;
                end
                S_WB: begin
                    reg_write  = !stall;
                    reg_dst    = (cls_q == C_IALU) || (cls_q == C_LW);
                    mem_to_reg = (cls_q == C_LW);
                end
                default: ;
            endcase
        end
        alu_op = ALUOP_W'(aop);
    end

    assign illegal = illegal_q && !reset;
    assign mem_err = mem_err_q && !reset;
    assign retired = reset ? '0 : retired_q;
endmodule

// File: tb/tb_mc_ctl.sv
// Self-checking bench for mc_ctl: per-cycle vector table plus trap/stall sequences.
module tb_mc_ctl;
    logic        clk = 1'b0, reset = 1'b1;
    logic [5:0]  opcode = '0, funct = '0;
    logic        mem_ready = 1'b0, alu_zero = 1'b0, stall = 1'b0;
    logic        ir_write, pc_write, iord, reg_dst, alu_src, reg_write;
    logic        mem_read, mem_write, mem_to_reg, illegal, mem_err;
    logic [1:0]  pc_src;
    logic [4:0]  alu_op;
    logic [31:0] retired;

    mc_ctl #(.ALUOP_W(5), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .stall(stall),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
        .reg_dst(reg_dst), .alu_src(alu_src), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .illegal(illegal), .mem_err(mem_err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic irw, pcw; logic [1:0] pcs; logic iord, rdst, asrc, rw, mr, mw, m2r;
        logic [4:0] aop; logic ill, merr;
    } ctl_t;

    typedef struct {
        string tag; logic rst; logic [5:0] op, fn; logic rdy, zero, stl;
        ctl_t exp; logic [31:0] ret;
    } vec_t;

    ctl_t        act;
    vec_t        vt[$];
    ctl_t        sb[$];
    logic [31:0] sbr[$];
    int          total = 0, bad = 0;

    assign act = {ir_write, pc_write, pc_src, iord, reg_dst, alu_src, reg_write,
                  mem_read, mem_write, mem_to_reg, alu_op, illegal, mem_err};

    function automatic ctl_t mk(logic irw, pcw, logic [1:0] pcs, logic io, rd, as, rw,
                                logic mr, mw, m2r, logic [4:0] aop, logic ill, merr);
        ctl_t c;
        c = {irw, pcw, pcs, io, rd, as, rw, mr, mw, m2r, aop, ill, merr};
        return c;
    endfunction

    function automatic vec_t mkv(string tag, logic rst, logic [5:0] op, fn,
                                 logic rdy, zero, stl, ctl_t exp, logic [31:0] ret);
        vec_t v;
        v.tag = tag; v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy;
        v.zero = zero; v.stl = stl; v.exp = exp; v.ret = ret;
        return v;
    endfunction

    task automatic step(input vec_t v);
        ctl_t e; logic [31:0] er;
        @(negedge clk);
        reset = v.rst; opcode = v.op; funct = v.fn;
        mem_ready = v.rdy; alu_zero = v.zero; stall = v.stl;
        sb.push_back(v.exp); sbr.push_back(v.ret);
        #3;
        e = sb.pop_front(); er = sbr.pop_front();
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s ctl: got %b want %b", v.tag, act, e);
        end
        total++;
        if (retired !== er) begin
            bad++;
            $display("FAIL %s retired: got %0d want %0d", v.tag, retired, er);
        end
    endtask

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           J = 6'b000010, ORI = 6'b001101, BAD = 6'b111111;

    initial begin
        ctl_t Z, FR, FW, EI, MEML, WBR;
        Z   = mk(0,0,2'd0,0,0,0,0,0,0,0,5'b00000,0,0);
        FR  = mk(1,1,2'd0,0,0,0,0,1,0,0,5'b00000,0,0);
        FW  = mk(0,0,2'd0,0,0,0,0,1,0,0,5'b00000,0,0);
        EI  = mk(0,0,2'd0,0,0,1,0,0,0,0,5'b00000,0,0);
        MEML= mk(0,0,2'd0,1,0,1,0,1,0,0,5'b00000,0,0);
        WBR = mk(0,0,2'd0,0,0,0,1,0,0,0,5'b00000,0,0);

        vt.push_back(mkv("reset",    1, R, 6'b100000, 0,0,0, Z, 0));
        vt.push_back(mkv("add_F",    0, R, 6'b100000, 1,0,0, FR, 0));
        vt.push_back(mkv("add_D",    0, R, 6'b100000, 0,0,0, Z, 0));
        vt.push_back(mkv("add_E",    0, R, 6'b100000, 0,0,0, Z, 0));
        vt.push_back(mkv("add_WB",   0, R, 6'b100000, 0,0,0, WBR, 0));
        vt.push_back(mkv("lw_F",     0, LW, 0, 1,0,0, FR, 1));
        vt.push_back(mkv("lw_D",     0, LW, 0, 0,0,0, Z, 1));
        vt.push_back(mkv("lw_E",     0, LW, 0, 0,0,0, EI, 1));
        vt.push_back(mkv("lw_M0",    0, LW, 0, 0,0,0, MEML, 1));
        vt.push_back(mkv("lw_M1",    0, LW, 0, 0,0,0, MEML, 1));
        vt.push_back(mkv("lw_M2",    0, LW, 0, 0,0,0, MEML, 1));
        vt.push_back(mkv("lw_M3",    0, LW, 0, 1,0,0, MEML, 1));
        vt.push_back(mkv("lw_WB",    0, LW, 0, 0,0,0, mk(0,0,2'd0,0,1,0,1,0,0,1,5'b00000,0,0), 1));
        vt.push_back(mkv("beq1_F",   0, BEQ, 0, 1,0,0, FR, 2));
        vt.push_back(mkv("beq1_D",   0, BEQ, 0, 0,0,0, Z, 2));
        vt.push_back(mkv("beq1_E",   0, BEQ, 0, 0,1,0, mk(0,1,2'd1,0,0,0,0,0,0,0,5'b00001,0,0), 2));
        vt.push_back(mkv("beq0_F",   0, BEQ, 0, 1,0,0, FR, 3));
        vt.push_back(mkv("beq0_D",   0, BEQ, 0, 0,0,0, Z, 3));
        vt.push_back(mkv("beq0_E",   0, BEQ, 0, 0,0,0, mk(0,0,2'd1,0,0,0,0,0,0,0,5'b00001,0,0), 3));
        vt.push_back(mkv("j_F",      0, J, 0, 1,0,0, FR, 4));
        vt.push_back(mkv("j_D",      0, J, 0, 0,0,0, mk(0,1,2'd2,0,0,0,0,0,0,0,5'b00000,0,0), 4));
        vt.push_back(mkv("sub_F",    0, R, 6'b100010, 1,0,0, FR, 5));
        vt.push_back(mkv("sub_D",    0, R, 6'b100010, 0,0,0, Z, 5));
        vt.push_back(mkv("sub_E",    0, R, 6'b100010, 0,0,0, mk(0,0,2'd0,0,0,0,0,0,0,0,5'b00001,0,0), 5));
        vt.push_back(mkv("sub_WB",   0, R, 6'b100010, 0,0,0, WBR, 5));
        vt.push_back(mkv("ori_F",    0, ORI, 0, 1,0,0, FR, 6));
        vt.push_back(mkv("ori_D",    0, ORI, 0, 0,0,0, Z, 6));
        vt.push_back(mkv("ori_E",    0, ORI, 0, 0,0,0, mk(0,0,2'd0,0,0,1,0,0,0,0,5'b11110,0,0), 6));
        vt.push_back(mkv("ori_WB",   0, ORI, 0, 0,0,0, mk(0,0,2'd0,0,1,0,1,0,0,0,5'b00000,0,0), 6));
        vt.push_back(mkv("sra_F",    0, R, 6'b000011, 1,0,0, FR, 7));
        vt.push_back(mkv("sra_D",    0, R, 6'b000011, 0,0,0, Z, 7));
        vt.push_back(mkv("sra_E",    0, R, 6'b000011, 0,0,0, mk(0,0,2'd0,0,0,1,0,0,0,0,5'b01011,0,0), 7));
        vt.push_back(mkv("sra_WB",   0, R, 6'b000011, 0,0,0, WBR, 7));
        vt.push_back(mkv("sw_F",     0, SW, 0, 1,0,0, FR, 8));
        vt.push_back(mkv("sw_D",     0, SW, 0, 0,0,0, Z, 8));
        vt.push_back(mkv("sw_E",     0, SW, 0, 0,0,0, EI, 8));
        vt.push_back(mkv("sw_M",     0, SW, 0, 1,0,0, mk(0,0,2'd0,1,0,1,0,0,1,0,5'b00000,0,0), 8));
        vt.push_back(mkv("mid_F",    0, R, 6'b100000, 1,0,0, FR, 9));
        vt.push_back(mkv("mid_D",    0, R, 6'b100000, 0,0,0, Z, 9));
        vt.push_back(mkv("mid_rst",  1, R, 6'b100000, 1,0,0, Z, 0));
        vt.push_back(mkv("mid_F2",   0, R, 6'b100000, 0,0,0, FW, 0));

        foreach (vt[i]) step(vt[i]);

        // illegal opcode: trap sticks until reset
        step(mkv("ill_F", 0, BAD, 0, 1,0,0, FR, 0));
        step(mkv("ill_D", 0, BAD, 0, 1,0,0, Z, 0));
        for (int i = 0; i < 20; i++)
            step(mkv("ill_trap", 0, R, 6'b100000, 1,0,0, mk(0,0,2'd0,0,0,0,0,0,0,0,5'b00000,1,0), 0));
        step(mkv("ill_rst", 1, R, 0, 0,0,0, Z, 0));
        step(mkv("ill_clr", 0, R, 0, 0,0,0, FW, 0));

        // fetch timeout after 15 waiting cycles
        step(mkv("to_rst", 1, R, 0, 0,0,0, Z, 0));
        for (int i = 0; i < 15; i++) step(mkv("to_wait", 0, R, 0, 0,0,0, FW, 0));
        for (int i = 0; i < 3; i++)
            step(mkv("to_trap", 0, R, 0, 1,0,0, mk(0,0,2'd0,0,0,0,0,0,0,0,5'b00000,0,1), 0));

        // ready on the 15th cycle completes without trapping
        step(mkv("tb_rst", 1, R, 0, 0,0,0, Z, 0));
        for (int i = 0; i < 14; i++) step(mkv("tb_wait", 0, R, 6'b100000, 0,0,0, FW, 0));
        step(mkv("tb_F",  0, R, 6'b100000, 1,0,0, FR, 0));
        step(mkv("tb_D",  0, R, 6'b100000, 0,0,0, Z, 0));
        step(mkv("tb_E",  0, R, 6'b100000, 0,0,0, Z, 0));
        step(mkv("tb_WB", 0, R, 6'b100000, 0,0,0, WBR, 0));
        step(mkv("tb_F2", 0, R, 6'b100000, 0,0,0, FW, 1));

        // reset wins over stall, then sw stalled in MEM with ready high
        step(mkv("st_rst", 1, SW, 0, 1,0,1, Z, 0));
        step(mkv("st_Fstl", 0, SW, 0, 1,0,1, Z, 0));
        step(mkv("st_F",  0, SW, 0, 1,0,0, FR, 0));
        step(mkv("st_D",  0, SW, 0, 0,0,0, Z, 0));
        step(mkv("st_E",  0, SW, 0, 0,0,0, EI, 0));
        for (int i = 0; i < 5; i++)
            step(mkv("st_Mstl", 0, SW, 0, 1,0,1, mk(0,0,2'd0,1,0,1,0,0,0,0,5'b00000,0,0), 0));
        step(mkv("st_M",  0, SW, 0, 1,0,0, mk(0,0,2'd0,1,0,1,0,0,1,0,5'b00000,0,0), 0));
        step(mkv("st_F2", 0, R, 0, 0,0,0, FW, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_ctl.md
Name: mc_ctl

Overview:
Multi-cycle control unit for the MIPS-subset datapath. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with a variable-latency memory. It emits per-state datapath controls, adds beq and j support, a stall input, a memory-timeout trap, an illegal-instruction trap and a retired-instruction counter. It sits between the instruction register and the datapath/register-file/memory enables.

Parameters:
ALUOP_W, 5, width of alu_op; must be >=5; codes zero-extended in upper bits.
MEM_TIMEOUT, 15, max cycles waiting for mem_ready in FETCH/MEM before trap; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]; valid from the cycle after ir_write
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes current access this cycle
alu_zero  in  1  ALU result==0 (beq compare)
stall  in  1  freeze FSM this cycle
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target
iord  out  1  memory address: 0=PC, 1=ALU result
reg_dst  out  1  0=rd, 1=rt
alu_src  out  1  0=rt, 1=imm/shamt
reg_write  out  1  register-file write strobe
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  writeback from memory
alu_op  out  ALUOP_W  ALU operation
illegal  out  1  sticky: unsupported opcode/funct trapped
mem_err  out  1  sticky: memory timeout trapped
retired  out  CNT_W  count of completed instructions; wraps to 0

Behaviour:
- Reset (reset=1 at edge): state->FETCH; illegal, mem_err, retired, wait counter->0. While reset is high, every output is 0. The first post-reset cycle is FETCH.
- ALU codes: add 00000, sub 00001, and 11000, nor 10001, or 11110, xor 10110, slt 00111, sll 01000, srl 01001, sra 01011.
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0; ->DECODE.
- DECODE: latch the instruction class from opcode/funct into an internal register.
  - Legal classes: R-ALU (funct add/sub/and/nor/or/xor/slt), SHIFT (funct sll/srl/sra), I-ALU (addi/andi/ori/xori), lw, sw, beq (000100), j (000010).
  - j: pc_write=1, pc_src=2, retire; ->FETCH.
  - Any other legal class: ->EXEC.
  - Otherwise: illegal<=1; ->TRAP.
- EXEC: alu_op per class.
  - R-ALU: alu_src=0.
  - SHIFT, I-ALU, lw, sw: alu_src=1; lw/sw use add.
  - beq: alu_src=0, alu_op=sub; pc_write=alu_zero, pc_src=1; retire; ->FETCH.
  - lw/sw: ->MEM. Others: ->WB.
- MEM: iord=1, alu_op=add, alu_src=1 held.
  - lw: mem_read=1. sw: mem_write=1.
  - On mem_ready: lw ->WB; sw retires ->FETCH.
- WB: reg_write=1, retire; ->FETCH.
  - R-ALU/SHIFT: reg_dst=0, mem_to_reg=0.
  - I-ALU: reg_dst=1, mem_to_reg=0.
  - lw: reg_dst=1, mem_to_reg=1.
- TRAP: all outputs 0 except illegal/mem_err/retired. Exit only by reset.
- Retire: retired+1 on the same edge as the transition to FETCH; wraps modulo 2^CNT_W.
- Memory wait: counter clears on entry to FETCH/MEM and increments each cycle with mem_ready=0 and stall=0.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_ready=0: mem_err<=1, ->TRAP.
  - mem_ready on the same cycle the count reaches MEM_TIMEOUT: the access completes, no trap.
- stall=1: state, counter and retired hold.
  - ir_write, pc_write, reg_write, mem_read and mem_write are forced 0; other outputs hold their state values.
  - A mem_ready during stall is ignored; the access re-requests when stall drops.
- reset beats stall and every other event in the same cycle. Reset mid-instruction abandons it without retiring.

Test Plan:
- Reset, then add (op 0, funct 100000) with mem_ready=1 in FETCH -> 4 cycles FETCH/DECODE/EXEC/WB; WB shows reg_write=1, reg_dst=0, alu_op=00000; retired=1.
- lw (100011), mem_ready delayed 3 cycles in MEM -> mem_read=1, iord=1 held 4 cycles; then WB with mem_to_reg=1, reg_dst=1; 8 cycles total with immediate fetch ready.
- beq with alu_zero=1 then alu_zero=0 -> first: pc_write=1, pc_src=1 in EXEC; second: pc_write=0; both retire, each 3 cycles.
- opcode 111111 -> illegal=1 in the cycle after DECODE; outputs stay 0 for 20 cycles; reset clears illegal.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> mem_err=1 and TRAP after 15 wait cycles. Repeat with mem_ready=1 on the 15th cycle -> no trap.
- stall=1 for 5 cycles during MEM of sw with mem_ready=1 -> mem_write=0, state held, retired unchanged; after stall drops, sw completes and retired increments.
